// File: rtl/axis_boxcar_decimator_if.sv
// AXI-Stream sample channel shared by the boxcar decimator's input and output sides.
// The master drives tdata/tvalid and the slave drives tready.
interface axis_boxcar_decimator_if #(
  parameter int unsigned DATA_W = 14
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_boxcar_decimator.sv
// Boxcar decimator: sums R accepted signed samples, then emits one result per block as
// sat(sum >>> S). The output side has a single holding register with full backpressure.
module axis_boxcar_decimator #(
  parameter int unsigned AXIS_TDATA_WIDTH = 14,
  parameter int unsigned CNTR_WIDTH       = 16,
  parameter int unsigned SHIFT_WIDTH      = 5
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [CNTR_WIDTH+SHIFT_WIDTH-1:0] cfg_data,
  axis_boxcar_decimator_if.slave            s_axis,
  axis_boxcar_decimator_if.master           m_axis,
  output logic                              sts_saturated
);

  localparam int unsigned W     = AXIS_TDATA_WIDTH;
  localparam int unsigned ACC_W = AXIS_TDATA_WIDTH + CNTR_WIDTH;

  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [CNTR_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNTR_WIDTH-1:0]        r_q, r_d;
  logic [SHIFT_WIDTH-1:0]       s_q, s_d;
  logic [W-1:0]                 tdata_q, tdata_d;
  logic                         tvalid_q, tvalid_d;
  logic                         sat_q, sat_d;

  logic                         s_ready;
  logic                         accept;
  logic                         first;
  logic                         last;
  logic [CNTR_WIDTH-1:0]        r_cfg, r_eff;
  logic [SHIFT_WIDTH-1:0]       s_raw, s_cfg, s_eff;
  logic signed [ACC_W-1:0]      sample_ext;
  logic signed [ACC_W-1:0]      sum;
  logic signed [ACC_W-1:0]      shifted;
  logic                         clip_hi, clip_lo;
  logic [W-1:0]                 result;

  always_comb begin
    s_ready = ~tvalid_q | m_axis.tready;
    accept  = s_axis.tvalid & s_ready;
    first   = (cnt_q == '0);

    r_cfg = cfg_data[CNTR_WIDTH-1:0];
    if (r_cfg == '0) begin
      r_cfg = CNTR_WIDTH'(1);
    end
    s_raw = cfg_data[CNTR_WIDTH+SHIFT_WIDTH-1:CNTR_WIDTH];
    s_cfg = s_raw;
    if (32'(s_raw) > ACC_W - 1) begin
      s_cfg = SHIFT_WIDTH'(ACC_W - 1);
    end

    // The first sample of a block uses the live config; later samples use the latched copy.
    r_eff = first ? r_cfg : r_q;
    s_eff = first ? s_cfg : s_q;
    last  = (({1'b0, cnt_q} + (CNTR_WIDTH+1)'(1)) == {1'b0, r_eff});

    sample_ext = {{(ACC_W-W){s_axis.tdata[W-1]}}, s_axis.tdata};
    sum        = acc_q + sample_ext;
    shifted    = sum >>> s_eff;
    clip_hi    = (shifted > OUT_MAX);
    clip_lo    = (shifted < OUT_MIN);
    if (clip_hi) begin
      result = OUT_MAX[W-1:0];
    end else if (clip_lo) begin
      result = OUT_MIN[W-1:0];
    end else begin
      result = shifted[W-1:0];
    end
  end

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    s_d      = s_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q & ~m_axis.tready;
    sat_d    = sat_q;
    if (accept) begin
      if (first) begin
        r_d = r_cfg;
        s_d = s_cfg;
      end
      // A block result loading on the same edge as a consume keeps tvalid high.
      if (last) begin
        acc_d    = '0;
        cnt_d    = '0;
        tdata_d  = result;
        tvalid_d = 1'b1;
        sat_d    = sat_q | clip_hi | clip_lo;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNTR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      r_q      <= '0;
      s_q      <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      s_q      <= s_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      sat_q    <= sat_d;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign sts_saturated = sat_q;

endmodule

// File: tb/tb_axis_boxcar_decimator.sv
// Bench for axis_boxcar_decimator: a behavioural model pushes expected block results into
// a queue as samples are accepted; the output side pops and compares on each handshake.
module tb_axis_boxcar_decimator;

  localparam int W     = 14;
  localparam int CW    = 16;
  localparam int SW    = 5;
  localparam int ACC_W = W + CW;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [CW+SW-1:0]  cfg_data;
  logic              sts_saturated;

  axis_boxcar_decimator_if #(.DATA_W(W)) s_axis ();
  axis_boxcar_decimator_if #(.DATA_W(W)) m_axis ();

  axis_boxcar_decimator #(
    .AXIS_TDATA_WIDTH(W),
    .CNTR_WIDTH      (CW),
    .SHIFT_WIDTH     (SW)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_data     (cfg_data),
    .s_axis       (s_axis),
    .m_axis       (m_axis),
    .sts_saturated(sts_saturated)
  );

  always #5 aclk = ~aclk;

  int     errors = 0;
  int     checks = 0;
  longint exp_q[$];

  // Reference model state, advanced at the falling edge from the stable handshake signals.
  longint      m_acc = 0;
  int unsigned m_cnt = 0;
  int unsigned m_r   = 1;
  int unsigned m_s   = 0;
  bit          prev_stall = 1'b0;
  logic [W-1:0] prev_data;

  always @(negedge aclk) begin
    longint v;
    longint got;
    if (!aresetn) begin
      m_acc = 0;
      m_cnt = 0;
      prev_stall = 1'b0;
      exp_q.delete();
    end else begin
      if (prev_stall) begin
        checks++;
        if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: tvalid=%b tdata=%h, required tvalid=1 tdata=%h",
                   m_axis.tvalid, m_axis.tdata, prev_data);
        end
      end
      if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
        got = longint'($signed(m_axis.tdata));
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: got %0d, required no output", got);
        end else begin
          v = exp_q.pop_front();
          if (got !== v) begin
            errors++;
            $display("FAIL scoreboard: got %0d, required %0d", got, v);
          end
        end
      end
      if (s_axis.tvalid === 1'b1 && s_axis.tready === 1'b1) begin
        if (m_cnt == 0) begin
          m_r = int'(cfg_data[CW-1:0]);
          if (m_r == 0) m_r = 1;
          m_s = int'(cfg_data[CW+SW-1:CW]);
          if (m_s > ACC_W - 1) m_s = ACC_W - 1;
        end
        m_acc = m_acc + longint'($signed(s_axis.tdata));
        m_cnt++;
        if (m_cnt == m_r) begin
          v = m_acc >>> m_s;
          if (v > 8191) v = 8191;
          if (v < -8192) v = -8192;
          exp_q.push_back(v);
          m_acc = 0;
          m_cnt = 0;
        end
      end
      prev_stall = (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b0);
      prev_data  = m_axis.tdata;
    end
  end

  function automatic logic [CW+SW-1:0] cfg(input int unsigned r, input int unsigned s);
    return {SW'(s), CW'(r)};
  endfunction

  // Present one sample and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input int d);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    s_axis.tdata  = W'(d);
    s_axis.tvalid = 1'b1;
    while (!acc && n < 2000) begin
      @(negedge aclk);
      acc = s_axis.tready;
      @(posedge aclk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: sample %0d not accepted after %0d cycles", d, n);
    end
  endtask

  task automatic idle();
    s_axis.tvalid = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge aclk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (m_axis.tvalid !== 1'b0 || m_axis.tdata !== '0 || sts_saturated !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tvalid=%b tdata=%h sat=%b, required 0 0 0",
               m_axis.tvalid, m_axis.tdata, sts_saturated);
    end
    checks++;
    if (s_axis.tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: got %b, required 1", s_axis.tready);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_basic_average();
    m_axis.tready = 1'b1;
    cfg_data = cfg(4, 2);
    send(100);
    send(200);
    send(-50);
    send(150);
    checks++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 14'd100) begin
      errors++;
      $display("FAIL basic_out: tvalid=%b tdata=%0d, required 1 100",
               m_axis.tvalid, $signed(m_axis.tdata));
    end
    idle();
    checks++;
    if (m_axis.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_single_cycle: tvalid=%b, required 0", m_axis.tvalid);
    end
    drain();
  endtask

  task automatic test_saturation();
    m_axis.tready = 1'b1;
    cfg_data = cfg(2, 0);
    send(8191);
    send(8191);
    checks++;
    if (m_axis.tdata !== 14'h1FFF || sts_saturated !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos: tdata=%h sat=%b, required 1fff 1", m_axis.tdata, sts_saturated);
    end
    send(-8192);
    send(-8192);
    checks++;
    if (m_axis.tdata !== 14'h2000 || sts_saturated !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg: tdata=%h sat=%b, required 2000 1", m_axis.tdata, sts_saturated);
    end
    idle();
    drain();
  endtask

  task automatic test_reset_mid_block();
    m_axis.tready = 1'b1;
    cfg_data = cfg(4, 2);
    send(7);
    send(9);
    idle();
    #1;
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_axis.tdata !== '0 || m_axis.tvalid !== 1'b0 || sts_saturated !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: tdata=%h tvalid=%b sat=%b, required 0 0 0",
               m_axis.tdata, m_axis.tvalid, sts_saturated);
    end
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    send(4);
    send(8);
    send(12);
    send(16);
    checks++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 14'd10) begin
      errors++;
      $display("FAIL reset_block: tvalid=%b tdata=%0d, required 1 10",
               m_axis.tvalid, $signed(m_axis.tdata));
    end
    idle();
    drain();
  endtask

  task automatic test_backpressure();
    cfg_data = cfg(1, 0);
    m_axis.tready = 1'b0;
    s_axis.tdata  = W'(1);
    s_axis.tvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_axis.tdata = W'(2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_axis.tready !== 1'b0 || m_axis.tvalid !== 1'b1 || m_axis.tdata !== 14'd1) begin
        errors++;
        $display("FAIL stall_%0d: s_tready=%b tvalid=%b tdata=%0d, required 0 1 1",
                 i, s_axis.tready, m_axis.tvalid, m_axis.tdata);
      end
      @(posedge aclk);
      #1;
    end
    m_axis.tready = 1'b1;
    send(2);
    send(3);
    idle();
    drain();
  endtask

  task automatic test_config_edges();
    m_axis.tready = 1'b1;
    // The shift field holds at most 31, which still exceeds ACC_W-1 and must clamp.
    cfg_data = cfg(0, 31);
    send(-5);
    checks++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 14'h3FFF) begin
      errors++;
      $display("FAIL clamp_neg: tvalid=%b tdata=%h, required 1 3fff", m_axis.tvalid, m_axis.tdata);
    end
    send(5);
    checks++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 14'h0000) begin
      errors++;
      $display("FAIL clamp_pos: tvalid=%b tdata=%h, required 1 0000", m_axis.tvalid, m_axis.tdata);
    end
    idle();
    drain();
    cfg_data = cfg(4, 0);
    send(1);
    send(2);
    cfg_data = cfg(2, 0);
    send(3);
    checks++;
    if (m_axis.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL cfg_midblock_early: tvalid=%b, required 0", m_axis.tvalid);
    end
    send(4);
    checks++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 14'd10) begin
      errors++;
      $display("FAIL cfg_midblock_close: tvalid=%b tdata=%0d, required 1 10",
               m_axis.tvalid, $signed(m_axis.tdata));
    end
    send(5);
    send(6);
    idle();
    drain();
  endtask

  task automatic test_random_stream();
    bit done;
    done = 1'b0;
    cfg_data = cfg(7, 3);
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          while ($urandom_range(0, 1) == 0) idle();
          send(int'($urandom_range(0, 16383)) - 8192);
        end
        s_axis.tvalid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge aclk);
          #1;
          m_axis.tready = $urandom_range(0, 1) == 1;
        end
        m_axis.tready = 1'b1;
      end
    join
    drain();
  endtask

  initial begin
    cfg_data      = cfg(1, 0);
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b1;
    test_reset();
    test_basic_average();
    test_saturation();
    test_reset_mid_block();
    test_backpressure();
    test_config_edges();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
